// File: rtl/sram_ctrl_pkg.sv
// Shared constants, response record and byte-strobe expansion for the cache data SRAM front-end.
package sram_ctrl_pkg;

    localparam int ADDR_W    = 6;
    localparam int LINE_W    = 128;
    localparam int DATA_W    = 64;
    localparam int STRB_W    = DATA_W / 8;
    localparam int RSP_DEPTH = 2;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              is_wr;
    } rsp_t;

    // Expand a per-byte strobe for one half of the line into the macro's active-low bit enables.
    // The unselected half stays all ones so its contents are preserved.
    function automatic logic [LINE_W-1:0] strobe_to_bwen(input logic half,
                                                         input logic [STRB_W-1:0] wstrb);
        logic [LINE_W-1:0] bwen;
        bwen = '1;
        for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
                bwen[int'(half)*DATA_W + 8*b +: 8] = 8'h00;
            end
        end
        return bwen;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous response FIFO; head entry is presented directly from storage registers.
module rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH
) (
    input  logic clock,
    input  logic rst_n,
    input  logic push,
    input  rsp_t push_data,
    input  logic pop,
    output rsp_t head,
    output logic full,
    output logic empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rsp_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; a push into a full FIFO is allowed only alongside a pop.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front-end for the 64x128 single-port cache data SRAM macro.
// One request register stage (s1) drives the macro pins; read data is captured from Q at the
// end of that cycle into a credit-guarded response FIFO, giving a two-cycle read latency.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_is_wr,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [LINE_W-1:0] sram_d,
    output logic [LINE_W-1:0] sram_bwen,
    input  logic [LINE_W-1:0] sram_q
);
    localparam int CRED_W = $clog2(RSP_DEPTH + 1);

    logic [CRED_W-1:0] credits;
    logic              accept;
    logic              rsp_pop;

    logic              s1_valid;
    logic              s1_wen;
    logic              s1_half;
    logic [ADDR_W-1:0] s1_line;
    logic [DATA_W-1:0] s1_wdata;
    logic [STRB_W-1:0] s1_wstrb;

    logic              s1_write;
    logic [DATA_W-1:0] q_half;
    rsp_t              push_data;
    rsp_t              fifo_head;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;

    // A freed response slot in this cycle can be reused immediately by a new request.
    assign rsp_valid = ~fifo_empty;
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign req_ready = (credits != '0) | rsp_pop;
    assign accept    = req_valid & req_ready;

    // Credits count free response slots, counting the s1 stage as already holding one.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CRED_W'(RSP_DEPTH);
        end else if (accept && !rsp_pop) begin
            credits <= credits - 1'b1;
        end else if (!accept && rsp_pop) begin
            credits <= credits + 1'b1;
        end
    end

    // s1 request register: loads on accept, otherwise drains to idle every cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_wen   <= 1'b0;
            s1_half  <= 1'b0;
            s1_line  <= '0;
            s1_wdata <= '0;
            s1_wstrb <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_wen   <= req_wen;
                s1_half  <= req_addr[0];
                s1_line  <= req_addr[ADDR_W:1];
                s1_wdata <= req_wdata;
                s1_wstrb <= req_wstrb;
            end
        end
    end

    // Macro pins come straight from s1 registers so they are glitch-free and idle when s1 is empty.
    assign s1_write  = s1_valid & s1_wen;
    assign sram_cen  = ~s1_valid;
    assign sram_wen  = ~s1_write;
    assign sram_a    = s1_valid ? s1_line : '0;
    assign sram_d    = s1_write ? {s1_wdata, s1_wdata} : '0;
    assign sram_bwen = s1_write ? strobe_to_bwen(s1_half, s1_wstrb) : '1;

    assign q_half          = s1_half ? sram_q[LINE_W-1:DATA_W] : sram_q[DATA_W-1:0];
    assign push_data.rdata = s1_wen ? '0 : q_half;
    assign push_data.is_wr = s1_wen;
    assign fifo_push       = s1_valid & (~fifo_full | rsp_pop);

    rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clock    (clock),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(push_data),
        .pop      (rsp_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rsp_rdata = fifo_head.rdata;
    assign rsp_is_wr = fifo_head.is_wr;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM macro plus a word-level reference memory and
// an expected-response queue filled at request acceptance.
module tb_sram_req_ctrl;

    logic          clock;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [6:0]    req_addr;
    logic [63:0]   req_wdata;
    logic [7:0]    req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_rdata;
    logic          rsp_is_wr;
    logic          sram_cen;
    logic          sram_wen;
    logic [5:0]    sram_a;
    logic [127:0]  sram_d;
    logic [127:0]  sram_bwen;
    logic [127:0]  sram_q;

    typedef struct {
        logic [63:0] data;
        logic        is_wr;
        int          acc_cyc;
    } exp_t;

    logic [127:0] sram_mem [64];
    logic [63:0]  ref_words [128];
    exp_t         exp_q [$];
    int           cyc;
    int           n_checks;
    int           n_pass;

    sram_req_ctrl dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_is_wr(rsp_is_wr),
        .sram_cen (sram_cen),
        .sram_wen (sram_wen),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_bwen(sram_bwen),
        .sram_q   (sram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Macro model: combinational read port, bit-masked write on the rising edge.
    assign sram_q = sram_mem[sram_a];
    always @(posedge clock) begin
        if (!sram_cen && !sram_wen)
            sram_mem[sram_a] <= (sram_mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
    end

    // One bus cycle, entered and left on a falling edge. Records what handshakes happened and
    // updates the reference model; comparisons are made by the callers.
    task automatic drive_cycle(input logic v, input logic wen, input logic [6:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wstrb, input logic rr,
                               output logic acc, output logic popped,
                               output logic [63:0] got_d, output logic got_w,
                               output logic [63:0] exp_d, output logic exp_w,
                               output int lat, output logic unexp);
        exp_t e;
        req_valid = v; req_wen = wen; req_addr = addr;
        req_wdata = wdata; req_wstrb = wstrb; rsp_ready = rr;
        #1;
        acc    = req_valid & req_ready;
        popped = rsp_valid & rsp_ready;
        got_d  = rsp_rdata;
        got_w  = rsp_is_wr;
        exp_d  = '0; exp_w = 1'b0; lat = 0; unexp = 1'b0;
        if (popped) begin
            if (exp_q.size() == 0) unexp = 1'b1;
            else begin
                e = exp_q.pop_front();
                exp_d = e.data; exp_w = e.is_wr; lat = cyc - e.acc_cyc;
            end
        end
        if (acc) begin
            e.acc_cyc = cyc;
            e.is_wr   = wen;
            if (wen) begin
                e.data = '0;
                for (int b = 0; b < 8; b++)
                    if (wstrb[b]) ref_words[addr][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.data = ref_words[addr];
            end
            exp_q.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic test_reset();
        logic [127:0] ones;
        ones = '1;
        rst_n = 1'b0;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_is_wr !== 1'b0)
            $display("FAIL reset_rsp: got valid=%b rdata=%h is_wr=%b expected 0/0/0", rsp_valid, rsp_rdata, rsp_is_wr);
        else n_pass++;
        n_checks++;
        if (sram_cen !== 1'b1 || sram_wen !== 1'b1 || sram_a !== 6'h0 || sram_d !== 128'h0 || sram_bwen !== ones)
            $display("FAIL reset_pins: got cen=%b wen=%b a=%h d=%h bwen=%h expected idle", sram_cen, sram_wen, sram_a, sram_d, sram_bwen);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clock);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic acc, pop, gw, ew, un;
        logic [63:0] gd, ed, last_rd;
        logic [127:0] exp_bwen;
        int lat;
        // full write of the upper half of line 2
        drive_cycle(1, 1, 7'h05, 64'h1122334455667788, 8'hFF, 1, acc, pop, gd, gw, ed, ew, lat, un);
        exp_bwen = {64'h0, {64{1'b1}}};
        n_checks++;
        if (acc !== 1'b1 || sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_a !== 6'd2)
            $display("FAIL wr_pins: got acc=%b cen=%b wen=%b a=%0d expected 1/0/0/2", acc, sram_cen, sram_wen, sram_a);
        else n_pass++;
        n_checks++;
        if (sram_d !== {2{64'h1122334455667788}} || sram_bwen !== exp_bwen)
            $display("FAIL wr_data_bwen: got d=%h bwen=%h expected bwen=%h", sram_d, sram_bwen, exp_bwen);
        else n_pass++;
        drive_cycle(1, 0, 7'h05, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
        n_checks++;
        if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_bwen !== {128{1'b1}} || sram_d !== 128'h0)
            $display("FAIL rd_pins: got cen=%b wen=%b bwen=%h d=%h expected read idle-data", sram_cen, sram_wen, sram_bwen, sram_d);
        else n_pass++;
        drive_cycle(1, 0, 7'h04, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
        n_checks++;
        if (pop !== 1'b1 || gw !== 1'b1 || gd !== 64'h0 || lat != 2)
            $display("FAIL wr_rsp: got pop=%b is_wr=%b rdata=%h lat=%0d expected 1/1/0/2", pop, gw, gd, lat);
        else n_pass++;
        // partial write of byte 0 in the upper half
        drive_cycle(1, 1, 7'h05, 64'hFFFF_FFFF_FFFF_FFAA, 8'h01, 1, acc, pop, gd, gw, ed, ew, lat, un);
        n_checks++;
        if (pop !== 1'b1 || gd !== 64'h1122334455667788 || lat != 2)
            $display("FAIL rd_full_write: got pop=%b rdata=%h lat=%0d expected 1122334455667788 lat 2", pop, gd, lat);
        else n_pass++;
        exp_bwen = {{56{1'b1}}, 8'h00, {64{1'b1}}};
        n_checks++;
        if (sram_bwen !== exp_bwen || sram_wen !== 1'b0)
            $display("FAIL partial_bwen: got bwen=%h wen=%b expected %h wen 0", sram_bwen, sram_wen, exp_bwen);
        else n_pass++;
        drive_cycle(1, 0, 7'h05, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
        n_checks++;
        if (pop !== 1'b1 || gd !== ed || gw !== 1'b0)
            $display("FAIL rd_low_half: got rdata=%h is_wr=%b expected %h 0", gd, gw, ed);
        else n_pass++;
        last_rd = 64'h0;
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            drive_cycle(0, 0, 7'h0, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
            if (pop) begin
                n_checks++;
                if (un || gd !== ed || gw !== ew)
                    $display("FAIL wr_rd_drain: got rdata=%h is_wr=%b expected %h %b", gd, gw, ed, ew);
                else n_pass++;
                last_rd = gd;
            end
        end
        n_checks++;
        if (last_rd !== 64'h11223344556677AA || exp_q.size() != 0)
            $display("FAIL rd_partial: got %h pending=%0d expected 11223344556677aa pending 0", last_rd, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic acc, pop, gw, ew, un;
        logic [63:0] gd, ed;
        logic [6:0] addr;
        int lat, n_acc, n_pop;
        for (int round = 0; round < 2; round++) begin
            n_acc = 0;
            addr = 7'($urandom);
            for (int i = 0; i < 4; i++) begin
                drive_cycle(1, 0, addr, 64'h0, 8'h00, 0, acc, pop, gd, gw, ed, ew, lat, un);
                if (acc) begin n_acc++; addr = 7'($urandom); end
            end
            req_valid = 1'b1;
            #1;
            n_checks++;
            if (n_acc != 2 || req_ready !== 1'b0)
                $display("FAIL bp_accepts: got %0d accepts ready=%b expected 2 accepts ready 0", n_acc, req_ready);
            else n_pass++;
            n_pop = 0;
            for (int i = 0; i < 8; i++) begin
                drive_cycle(0, 0, 7'h0, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
                if (pop) begin
                    n_pop++;
                    n_checks++;
                    if (un || gd !== ed || gw !== 1'b0)
                        $display("FAIL bp_order: got rdata=%h is_wr=%b expected %h 0", gd, gw, ed);
                    else n_pass++;
                end
            end
            n_checks++;
            if (n_pop != 2 || exp_q.size() != 0)
                $display("FAIL bp_drain: got %0d responses pending=%0d expected 2 pending 0", n_pop, exp_q.size());
            else n_pass++;
        end
    endtask

    task automatic test_streaming();
        logic acc, pop, gw, ew, un;
        logic [63:0] gd, ed;
        int lat, n_acc, n_pop, n_bad;
        n_acc = 0; n_pop = 0; n_bad = 0;
        for (int i = 0; i < 22; i++) begin
            drive_cycle(i < 16, 0, 7'($urandom), 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
            if (acc) n_acc++;
            if (pop) begin
                n_pop++;
                n_checks++;
                if (un || gd !== ed || lat != 2)
                    $display("FAIL stream_rsp: got rdata=%h lat=%0d expected %h lat 2", gd, lat, ed);
                else n_pass++;
            end
        end
        n_checks++;
        if (n_acc != 16 || n_pop != 16)
            $display("FAIL stream_count: got %0d accepts %0d responses expected 16 16", n_acc, n_pop);
        else n_pass++;
    endtask

    task automatic test_zero_strobe();
        logic acc, pop, gw, ew, un;
        logic [63:0] gd, ed;
        logic [6:0] addr;
        int lat;
        addr = 7'($urandom);
        drive_cycle(1, 1, addr, 64'($urandom) << 32 | 64'($urandom), 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
        n_checks++;
        if (acc !== 1'b1 || sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_bwen !== {128{1'b1}})
            $display("FAIL zero_strobe_pins: got acc=%b cen=%b wen=%b bwen=%h expected 1/0/0/all ones", acc, sram_cen, sram_wen, sram_bwen);
        else n_pass++;
        drive_cycle(1, 0, addr, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
        drive_cycle(0, 0, 7'h0, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
        n_checks++;
        if (pop !== 1'b1 || gw !== 1'b1 || gd !== 64'h0)
            $display("FAIL zero_strobe_rsp: got pop=%b is_wr=%b rdata=%h expected 1/1/0", pop, gw, gd);
        else n_pass++;
        drive_cycle(0, 0, 7'h0, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
        n_checks++;
        if (pop !== 1'b1 || gd !== ed || gw !== 1'b0)
            $display("FAIL zero_strobe_unchanged: got rdata=%h expected %h", gd, ed);
        else n_pass++;
    endtask

    task automatic test_random();
        logic acc, pop, gw, ew, un, v, wen, rr, hold, cur_v, cur_w, prev_w;
        logic [63:0] gd, ed, wdata, cur_d, prev_d;
        logic [6:0] addr;
        logic [7:0] wstrb;
        int lat, n_bad;
        n_bad = 0; hold = 1'b0; prev_d = '0; prev_w = 1'b0;
        wen = 0; addr = 0; wdata = 0; wstrb = 0;
        v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!v) begin
                v     = ($urandom_range(0, 9) < 7);
                wen   = 1'($urandom);
                addr  = 7'($urandom);
                wdata = {32'($urandom), 32'($urandom)};
                wstrb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            end
            rr = ($urandom_range(0, 3) != 0);
            cur_v = rsp_valid; cur_d = rsp_rdata; cur_w = rsp_is_wr;
            if (hold) begin
                n_checks++;
                if (cur_v !== 1'b1 || cur_d !== prev_d || cur_w !== prev_w)
                    $display("FAIL rand_hold: got valid=%b rdata=%h is_wr=%b expected 1 %h %b", cur_v, cur_d, cur_w, prev_d, prev_w);
                else n_pass++;
            end
            hold = cur_v & ~rr; prev_d = cur_d; prev_w = cur_w;
            drive_cycle(v, wen, addr, wdata, wstrb, rr, acc, pop, gd, gw, ed, ew, lat, un);
            if (acc) v = 1'b0;
            if (pop) begin
                n_checks++;
                if (un || gd !== ed || gw !== ew)
                    $display("FAIL rand_rsp: got rdata=%h is_wr=%b expected %h %b unexpected=%b", gd, gw, ed, ew, un);
                else n_pass++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, 0, 7'h0, 64'h0, 8'h00, 1, acc, pop, gd, gw, ed, ew, lat, un);
            if (pop) begin
                n_checks++;
                if (un || gd !== ed || gw !== ew)
                    $display("FAIL rand_drain: got rdata=%h is_wr=%b expected %h %b", gd, gw, ed, ew);
                else n_pass++;
            end
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rand_idle: got pending=%0d rsp_valid=%b req_ready=%b expected 0 0 1", exp_q.size(), rsp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_midop_reset();
        logic acc, pop, gw, ew, un;
        logic [63:0] gd, ed;
        int lat;
        drive_cycle(1, 0, 7'($urandom), 64'h0, 8'h00, 0, acc, pop, gd, gw, ed, ew, lat, un);
        drive_cycle(1, 0, 7'($urandom), 64'h0, 8'h00, 0, acc, pop, gd, gw, ed, ew, lat, un);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || sram_cen !== 1'b1 || sram_bwen !== {128{1'b1}})
            $display("FAIL midop_reset: got rsp_valid=%b cen=%b bwen=%h expected 0 1 all ones", rsp_valid, sram_cen, sram_bwen);
        else n_pass++;
        exp_q.delete();
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL midop_release: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        for (int l = 0; l < 64; l++) begin
            sram_mem[l] = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            ref_words[2*l]     = sram_mem[l][63:0];
            ref_words[2*l + 1] = sram_mem[l][127:64];
        end
        test_reset();
        test_write_read();
        test_backpressure();
        test_streaming();
        test_zero_strobe();
        test_random();
        test_midop_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
